wav_stream_arbiter: RTL and testbench

Round-robin arbiter that merges N valid/ready byte streams into one drain stream. Each requesting source gets a grant that lasts for up to BURST transfers. The arbiter sits between several stream sources (counter sources, test generators) and a single stream drain. It carries the same tvalid/tready/tdata handshake on every port, so sources and drains connect without adaptation.

---
 rtl/wav_stream_arbiter_pkg.sv | 43 ++++
 rtl/wav_rr_pick.sv | 30 +++
 rtl/wav_stream_arbiter.sv | 102 ++++++++++
 tb/tb_wav_stream_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/wav_stream_arbiter_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
// Kept free of module parameters so other arbiters can reuse the picker function.
package wav_stream_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GNT  = 1'b1
    } state_t;

    localparam int MAX_N  = 16;
    localparam int MAX_IW = 4;

    // Width of an index into `value` entries, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

    // First set bit of req at or above ptr, wrapping from n-1 to 0.
    // Returns ptr when no bit is set; callers qualify the result with |req.
    function automatic logic [MAX_IW-1:0] rr_pick(
        input logic [MAX_N-1:0]  req,
        input logic [MAX_IW-1:0] ptr,
        input int                n
    );
        logic [MAX_IW:0]   cand;
        logic [MAX_IW-1:0] idx;
        logic              found;
        idx   = ptr;
        found = 1'b0;
        for (int i = 0; i < MAX_N; i++) begin
            cand = {1'b0, ptr} + (MAX_IW+1)'(i);
            if (cand >= (MAX_IW+1)'(n)) begin
                cand = cand - (MAX_IW+1)'(n);
            end
            if (!found && (i < n) && req[cand[MAX_IW-1:0]]) begin
                idx   = cand[MAX_IW-1:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wav_rr_pick.sv
// Combinational round-robin priority picker: lowest requester at or above ptr,
// wrapping. Pure function of its inputs so it can be shared by other arbiters.
module wav_rr_pick
    import wav_stream_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [MAX_N-1:0]  req_ext;
    logic [MAX_IW-1:0] ptr_ext;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the block can leave it holding a value (which infers a latch).
    always_comb begin
        req_ext          = '0;
        req_ext[N-1:0]   = req;
        ptr_ext          = '0;
        ptr_ext[IW-1:0]  = ptr;
    end

    assign idx = IW'(rr_pick(req_ext, ptr_ext, N));
    assign any = |req;

endmodule

// File: rtl/wav_stream_arbiter.sv
// Round-robin merge of N valid/ready byte streams into one drain stream.
// Each grant lasts up to BURST transfers; the data and ready paths are combinational.
module wav_stream_arbiter
    import wav_stream_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ctl_run,
    input  logic [N-1:0]                s_tvalid,
    output logic [N-1:0]                s_tready,
    input  logic [N*DW-1:0]             s_tdata,
    output logic                        m_tvalid,
    input  logic                        m_tready,
    output logic [DW-1:0]               m_tdata,
    output logic [clog2_min1(N)-1:0]    sts_gnt,
    output logic                        sts_busy
);

    localparam int IW = clog2_min1(N);
    localparam int CW = clog2_min1(BURST);

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] gnt;
    logic [CW-1:0] cnt;

    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          gnt_vld;
    logic          xfer;
    logic          last_beat;
    logic [IW-1:0] next_ptr;

    wav_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req (s_tvalid),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign gnt_vld   = s_tvalid[gnt];
    assign xfer      = (state == GNT) && gnt_vld && m_tready;
    assign last_beat = (cnt == CW'(BURST - 1));
    // The released source drops to lowest priority for the next round.
    assign next_ptr  = (gnt == IW'(N - 1)) ? '0 : gnt + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            gnt   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (ctl_run && pick_any) begin
                        state <= GNT;
                        gnt   <= pick_idx;
                    end
                end
                GNT: begin
                    // An idle source can never transfer, so the two release causes
                    // are mutually exclusive and collapse into one release.
                    if (!gnt_vld || (xfer && last_beat)) begin
                        state <= IDLE;
                        ptr   <= next_ptr;
                        cnt   <= '0;
                    end else if (xfer) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        s_tready = '0;
        m_tvalid = 1'b0;
        m_tdata  = s_tdata[int'(gnt)*DW +: DW];
        if (state == GNT) begin
            m_tvalid      = gnt_vld;
            s_tready[gnt] = m_tready;
        end
    end

    assign sts_busy = (state == GNT);
    assign sts_gnt  = gnt;

endmodule

// File: tb/tb_wav_stream_arbiter.sv
// Self-checking bench for wav_stream_arbiter (N=4, DW=8, BURST=4): a per-cycle
// vector table plus scoreboarded single-source and reset sequences.
module tb_wav_stream_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            ctl_run;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [N*DW-1:0] s_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic [DW-1:0]   m_tdata;
    logic [1:0]      sts_gnt;
    logic            sts_busy;

    always #5 clk = ~clk;

    wav_stream_arbiter #(
        .N     (N),
        .DW    (DW),
        .BURST (BURST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ctl_run  (ctl_run),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .sts_gnt  (sts_gnt),
        .sts_busy (sts_busy)
    );

    typedef struct {
        logic       run;
        logic [3:0] vld;
        logic       mrdy;
        logic       busy;
        logic [1:0] gnt;
        logic [3:0] srdy;
        logic       mvld;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic run, input logic [3:0] vld, input logic mrdy,
                       input logic busy, input logic [1:0] gnt, input logic [3:0] srdy,
                       input logic mvld);
        vec_t v;
        v.run = run; v.vld = vld; v.mrdy = mrdy; v.busy = busy;
        v.gnt = gnt; v.srdy = srdy; v.mvld = mvld;
        tbl.push_back(v);
    endtask

    task automatic add_idle(input logic run, input logic [3:0] vld);
        add(run, vld, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
    endtask

    // Single source 2 sends 0..9; expected bytes enter the scoreboard as driven.
    task automatic single_source();
        logic [7:0] sb[$];
        int         bursts[$];
        int         exp_b[3];
        int         d, pushed, beats, idle_run;
        logic       prev_busy, busy_s, xfer_s;
        exp_b = '{4, 4, 2};
        d = 0; pushed = -1; beats = 0; idle_run = 0; prev_busy = 1'b0;
        ctl_run  = 1'b1;
        m_tready = 1'b1;
        for (int cyc = 0; cyc < 60 && bursts.size() < 3; cyc++) begin
            if (d < 10) begin
                s_tvalid        = 4'b0100;
                s_tdata[23:16]  = 8'(d);
                if (d != pushed) begin
                    sb.push_back(8'(d));
                    pushed = d;
                end
            end else begin
                s_tvalid = 4'b0000;
            end
            s_tdata[7:0]   = 8'($urandom);
            s_tdata[15:8]  = 8'($urandom);
            s_tdata[31:24] = 8'($urandom);
            #1;
            busy_s = sts_busy;
            xfer_s = m_tvalid & m_tready;
            check("ss s_tready", 32'(s_tready), busy_s ? 32'h4 : 32'h0);
            if (busy_s) check("ss gnt", 32'(sts_gnt), 32'd2);
            if (xfer_s) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL ss data: transfer of 0x%0h with empty scoreboard", m_tdata);
                end else begin
                    check("ss data", 32'(m_tdata), 32'(sb.pop_front()));
                end
                beats++;
            end
            if (busy_s && !prev_busy && bursts.size() > 0) check("ss idle gap", idle_run, 1);
            if (!busy_s && prev_busy) begin
                bursts.push_back(beats);
                beats    = 0;
                idle_run = 0;
            end
            if (!busy_s) idle_run++;
            prev_busy = busy_s;
            tick();
            if (xfer_s) d++;
        end
        check("ss burst count", bursts.size(), 3);
        for (int i = 0; i < bursts.size() && i < 3; i++) begin
            check($sformatf("ss burst%0d len", i), bursts[i], exp_b[i]);
        end
        check("ss scoreboard empty", sb.size(), 0);
    endtask

    initial begin
        rst      = 1'b1;
        ctl_run  = 1'b0;
        s_tvalid = '0;
        m_tready = 1'b0;
        s_tdata  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        #2;
        check("reset busy", 32'(sts_busy), 0);
        check("reset gnt", 32'(sts_gnt), 0);
        check("reset s_tready", 32'(s_tready), 0);
        check("reset m_tvalid", 32'(m_tvalid), 0);
        tick();
        rst = 1'b0;

        // Fairness: all valid, grants rotate 0,1,2,3,0 with 4 beats each and one idle.
        add_idle(1'b1, 4'b1111);
        for (int k = 0; k < 5; k++) begin
            for (int t = 0; t < 4; t++) begin
                add(1'b1, 4'b1111, 1'b1, 1'b1, 2'(k % 4), 4'b0001 << (k % 4), 1'b1);
            end
            if (k < 4) add_idle(1'b1, 4'b1111);
        end
        // Back-pressure on source 1: ready mirrors drain, release after 4th beat.
        add_idle(1'b1, 4'b0010);
        for (int t = 0; t < 7; t++) begin
            add(1'b1, 4'b0010, (t % 2) == 0, 1'b1, 2'd1,
                ((t % 2) == 0) ? 4'b0010 : 4'b0000, 1'b1);
        end
        add_idle(1'b1, 4'b0000);
        // Early release of source 3 after 2 beats; ptr wraps to 0, so 1 beats 3.
        add_idle(1'b1, 4'b1000);
        add(1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b1);
        add(1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b1);
        add(1'b1, 4'b0010, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0);
        add_idle(1'b1, 4'b1010);
        add(1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b0);
        add_idle(1'b1, 4'b0000);
        // ctl_run drops mid-burst: burst completes, IDLE holds, regrant next cycle.
        add_idle(1'b1, 4'b0011);
        for (int t = 0; t < 4; t++) add(1'b0, 4'b0011, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1);
        for (int t = 0; t < 3; t++) add_idle(1'b0, 4'b0011);
        add_idle(1'b1, 4'b0011);
        add(1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b0);
        add_idle(1'b1, 4'b0000);

        for (int i = 0; i < tbl.size(); i++) begin
            ctl_run  = tbl[i].run;
            s_tvalid = tbl[i].vld;
            m_tready = tbl[i].mrdy;
            #1;
            check($sformatf("row%0d busy", i), 32'(sts_busy), 32'(tbl[i].busy));
            check($sformatf("row%0d s_tready", i), 32'(s_tready), 32'(tbl[i].srdy));
            check($sformatf("row%0d m_tvalid", i), 32'(m_tvalid), 32'(tbl[i].mvld));
            if (tbl[i].busy) begin
                check($sformatf("row%0d gnt", i), 32'(sts_gnt), 32'(tbl[i].gnt));
                check($sformatf("row%0d m_tdata", i), 32'(m_tdata), 32'h0A0 + 32'(tbl[i].gnt));
            end
            tick();
        end

        single_source();

        // Reset pulse at the 2nd beat of a grant to source 2 (ptr is 3 beforehand).
        s_tdata  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        ctl_run  = 1'b1;
        m_tready = 1'b1;
        s_tvalid = 4'b0100;
        #1;
        check("rp idle", 32'(sts_busy), 0);
        tick();
        check("rp first beat gnt", 32'(sts_gnt), 2);
        check("rp first beat busy", 32'(sts_busy), 1);
        tick();
        rst = 1'b1;
        #1;
        check("rp busy in reset", 32'(sts_busy), 0);
        check("rp gnt in reset", 32'(sts_gnt), 0);
        check("rp s_tready in reset", 32'(s_tready), 0);
        check("rp m_tvalid in reset", 32'(m_tvalid), 0);
        tick();
        rst      = 1'b0;
        s_tvalid = 4'b1111;
        #1;
        check("rp post idle", 32'(sts_busy), 0);
        tick();
        check("rp regrant busy", 32'(sts_busy), 1);
        check("rp regrant from ptr0", 32'(sts_gnt), 0);
        s_tvalid = 4'b0000;
        tick();
        check("rp released", 32'(sts_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
